// File: rtl/ioctl_host.sv
// Host-side driver for the ioctl transfer interface: downloads bytes from a
// source memory to the core, or uploads bytes from the core into a capture memory.
module ioctl_host #(
    parameter int SRC_ADDRESSWIDTH = 10,
    parameter int CAP_ADDRESSWIDTH = 10,
    parameter int WR_SPACING       = 4,
    parameter int UPLOAD_SETTLE    = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_download,
    input  logic                        start_upload,
    input  logic [7:0]                  index,
    input  logic [24:0]                 length,
    output logic [SRC_ADDRESSWIDTH-1:0] src_addr,
    input  logic [7:0]                  src_data,
    output logic [CAP_ADDRESSWIDTH-1:0] cap_addr,
    output logic [7:0]                  cap_data,
    output logic                        cap_we,
    output logic                        ioctl_download,
    output logic                        ioctl_upload,
    output logic                        ioctl_wr,
    output logic [24:0]                 ioctl_addr,
    output logic [7:0]                  ioctl_dout,
    output logic [7:0]                  ioctl_index,
    input  logic [7:0]                  ioctl_din,
    output logic                        busy,
    output logic                        done,
    output logic [3:0]                  dbg_state
);

    // DL_GAP always takes at least one cycle so ioctl_addr outlives ioctl_wr by a cycle.
    localparam int GAP_CYCLES = (WR_SPACING > 4) ? WR_SPACING - 3 : 1;

    typedef enum logic [3:0] {
        IDLE, DL_FETCH, DL_DATA, DL_WR, DL_GAP, DL_END, UL_SETTLE, UL_CAPTURE, UL_END
    } state_t;

    state_t      state, state_nxt;
    logic [24:0] len_q;
    logic [24:0] addr_inc;
    logic [7:0]  cnt;
    logic        last_byte, accept_dl, accept_ul, len_zero, gap_end, settle_end;

    assign addr_inc   = ioctl_addr + 25'd1;
    assign last_byte  = (ioctl_addr == len_q - 25'd1);
    assign accept_dl  = (state == IDLE) && start_download;
    assign accept_ul  = (state == IDLE) && !start_download && start_upload;
    assign len_zero   = (length == 25'd0);
    assign gap_end    = (cnt == 8'(GAP_CYCLES - 1));
    assign settle_end = (cnt == 8'(UPLOAD_SETTLE - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept_dl && !len_zero)      state_nxt = DL_FETCH;
                else if (accept_ul && !len_zero) state_nxt = UL_SETTLE;
            end
            DL_FETCH:   state_nxt = DL_DATA;
            DL_DATA:    state_nxt = DL_WR;
            DL_WR:      state_nxt = DL_GAP;
            DL_GAP:     if (gap_end) state_nxt = last_byte ? DL_END : DL_FETCH;
            DL_END:     state_nxt = IDLE;
            UL_SETTLE:  if (settle_end) state_nxt = UL_CAPTURE;
            UL_CAPTURE: state_nxt = last_byte ? UL_END : UL_SETTLE;
            UL_END:     state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // src_addr is presented on entry to DL_FETCH so the 1-cycle memory
    // returns the byte during DL_DATA and ioctl_dout is valid alongside ioctl_wr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            len_q       <= '0;
            src_addr    <= '0;
            cap_addr    <= '0;
            cap_data    <= '0;
            cap_we      <= 1'b0;
            ioctl_addr  <= '0;
            ioctl_dout  <= '0;
            ioctl_index <= '0;
            done        <= 1'b0;
        end else begin
            cnt    <= (state_nxt != state) ? 8'd0 : cnt + 8'd1;
            cap_we <= (state == UL_CAPTURE);
            done   <= (state == DL_END) || (state == UL_END) ||
                      ((accept_dl || accept_ul) && len_zero);
            if (accept_dl || accept_ul) begin
                ioctl_index <= index;
                len_q       <= length;
                ioctl_addr  <= '0;
                if (accept_dl) src_addr <= '0;
            end
            case (state)
                DL_DATA: ioctl_dout <= src_data;
                DL_GAP: begin
                    if (gap_end && !last_byte) begin
                        ioctl_addr <= addr_inc;
                        src_addr   <= addr_inc[SRC_ADDRESSWIDTH-1:0];
                    end
                end
                UL_CAPTURE: begin
                    cap_addr <= ioctl_addr[CAP_ADDRESSWIDTH-1:0];
                    cap_data <= ioctl_din;
                    if (!last_byte) ioctl_addr <= addr_inc;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ioctl_download = (state == DL_FETCH) || (state == DL_DATA) || (state == DL_WR) ||
                         (state == DL_GAP) || (state == DL_END);
        ioctl_upload   = (state == UL_SETTLE) || (state == UL_CAPTURE) || (state == UL_END);
        ioctl_wr       = (state == DL_WR);
        busy           = (state != IDLE);
        dbg_state      = state;
    end

endmodule

// File: tb/tb_ioctl_host.sv
// Scoreboard bench for ioctl_host: drivers push expected beats into queues,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_ioctl_host;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        start_download, start_upload;
    logic [7:0]  index;
    logic [24:0] length;
    logic [9:0]  src_addr;
    logic [7:0]  src_data;
    logic [9:0]  cap_addr;
    logic [7:0]  cap_data;
    logic        cap_we, ioctl_download, ioctl_upload, ioctl_wr, busy, done;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout, ioctl_index, ioctl_din;
    logic [3:0]  dbg_state;

    logic        d2_start_download, d2_start_upload;
    logic [7:0]  d2_index;
    logic [24:0] d2_length;
    logic [1:0]  d2_src_addr;
    logic [7:0]  d2_src_data;
    logic [9:0]  d2_cap_addr;
    logic [7:0]  d2_cap_data;
    logic        d2_cap_we, d2_download, d2_upload, d2_wr, d2_busy, d2_done;
    logic [24:0] d2_ioctl_addr;
    logic [7:0]  d2_dout, d2_ioctl_index, d2_din;
    logic [3:0]  d2_dbg_state;

    ioctl_host u_dut (
        .clk(clk), .reset(reset), .start_download(start_download), .start_upload(start_upload),
        .index(index), .length(length), .src_addr(src_addr), .src_data(src_data),
        .cap_addr(cap_addr), .cap_data(cap_data), .cap_we(cap_we),
        .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
        .ioctl_din(ioctl_din), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    ioctl_host #(.SRC_ADDRESSWIDTH(2)) u_dut2 (
        .clk(clk), .reset(reset), .start_download(d2_start_download), .start_upload(d2_start_upload),
        .index(d2_index), .length(d2_length), .src_addr(d2_src_addr), .src_data(d2_src_data),
        .cap_addr(d2_cap_addr), .cap_data(d2_cap_data), .cap_we(d2_cap_we),
        .ioctl_download(d2_download), .ioctl_upload(d2_upload), .ioctl_wr(d2_wr),
        .ioctl_addr(d2_ioctl_addr), .ioctl_dout(d2_dout), .ioctl_index(d2_ioctl_index),
        .ioctl_din(d2_din), .busy(d2_busy), .done(d2_done), .dbg_state(d2_dbg_state)
    );

    // Memories and core model: 1-cycle source ROM, capture RAM, din = addr+0x40 two cycles late.
    logic [7:0] src_mem [0:1023];
    logic [7:0] cap_mem [0:1023];
    logic [7:0] din_d1;
    always @(posedge clk) begin
        src_data    <= src_mem[src_addr];
        d2_src_data <= src_mem[10'(d2_src_addr)];
        din_d1      <= ioctl_addr[7:0] + 8'h40;
        ioctl_din   <= din_d1;
        if (cap_we) cap_mem[cap_addr] <= cap_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int last_wr = -1;
    int last_cap = -1;
    int cap_cnt = 0;
    int ul_cycles = 0;
    int d2_done_cnt = 0;

    logic [40:0] wr_q[$];
    logic [17:0] cap_q[$];
    logic [7:0]  done_q[$];
    logic [34:0] wr2_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 64'({cap_we, ioctl_download, ioctl_upload, ioctl_wr, busy, done}), 64'd0);
        check({tag, "_addr"}, 64'({src_addr, cap_addr, ioctl_addr}), 64'd0);
        check({tag, "_data"}, 64'({cap_data, ioctl_dout, ioctl_index}), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (ioctl_wr) begin
                check("wr_expected", 64'(wr_q.size() > 0), 64'd1);
                if (wr_q.size() > 0)
                    check("wr_beat", 64'({ioctl_addr, ioctl_dout, ioctl_index}), 64'(wr_q.pop_front()));
                if (last_wr >= 0) check("wr_spacing", 64'(cyc - last_wr), 64'd4);
                last_wr = cyc;
                check("wr_during_upload", 64'(ioctl_upload), 64'd0);
            end
            if (cap_we) begin
                cap_cnt++;
                check("cap_expected", 64'(cap_q.size() > 0), 64'd1);
                if (cap_q.size() > 0)
                    check("cap_beat", 64'({cap_addr, cap_data}), 64'(cap_q.pop_front()));
                if (last_cap >= 0) check("cap_spacing", 64'(cyc - last_cap), 64'd4);
                last_cap = cyc;
            end
            if (done) begin
                check("done_expected", 64'(done_q.size() > 0), 64'd1);
                if (done_q.size() > 0)
                    check("done_state", 64'({ioctl_index, ioctl_download, ioctl_upload, busy}),
                          64'({done_q.pop_front(), 3'b000}));
            end
            if (busy) check("one_active_flag", 64'(ioctl_download ^ ioctl_upload), 64'd1);
            if (ioctl_upload) ul_cycles++;
            if (d2_wr) begin
                check("d2_wr_expected", 64'(wr2_q.size() > 0), 64'd1);
                if (wr2_q.size() > 0)
                    check("d2_wr_beat", 64'({d2_ioctl_addr, d2_src_addr, d2_dout}), 64'(wr2_q.pop_front()));
            end
            if (d2_done) d2_done_cnt++;
        end
    end

    task automatic issue(input logic dl, input logic ul, input logic [7:0] idx, input logic [24:0] len);
        @(posedge clk); #1;
        start_download = dl; start_upload = ul; index = idx; length = len;
        @(posedge clk); #1;
        start_download = 1'b0; start_upload = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        check({name, "_done_seen"}, 64'(seen), 64'd1);
        @(negedge clk);
    endtask

    task automatic check_queues(input string name);
        check({name, "_queues_empty"}, 64'(wr_q.size() + cap_q.size() + done_q.size()), 64'd0);
        check({name, "_idle"}, 64'({busy, ioctl_download, ioctl_upload}), 64'd0);
    endtask

    logic [7:0] rom8 [8];

    initial begin
        int ul_before, wcount;
        bit seen2;
        rom8 = '{8'h00, 8'h00, 8'h43, 8'h0B, 8'h0F, 8'h10, 8'h01, 8'h00};
        for (int i = 0; i < 1024; i++) src_mem[i] = 8'(i * 5 + 17);
        for (int i = 0; i < 8; i++) src_mem[i] = rom8[i];
        start_download = 1'b0; start_upload = 1'b0; index = '0; length = '0;
        d2_start_download = 1'b0; d2_start_upload = 1'b0; d2_index = '0; d2_length = '0; d2_din = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_all_zero("after_reset");

        // Download of 8 bytes, index 3
        for (int i = 0; i < 8; i++) wr_q.push_back({25'(i), rom8[i], 8'd3});
        done_q.push_back(8'd3);
        last_wr = -1;
        issue(1'b1, 1'b0, 8'd3, 25'd8);
        wait_done("dl8", 100);
        check("dl8_done_single", 64'(done), 64'd0);
        check("dl8_index_kept", 64'(ioctl_index), 64'd3);
        check_queues("dl8");

        // Upload of 5 bytes, index 2
        for (int i = 0; i < 5; i++) cap_q.push_back({10'(i), 8'(8'h40 + i)});
        done_q.push_back(8'd2);
        last_cap = -1; cap_cnt = 0;
        issue(1'b0, 1'b1, 8'd2, 25'd5);
        wait_done("ul5", 100);
        check("ul5_cap_count", 64'(cap_cnt), 64'd5);
        for (int i = 0; i < 5; i++) check("ul5_capture_mem", 64'(cap_mem[i]), 64'(8'h40 + i));
        check_queues("ul5");

        // Simultaneous requests, then upload request while busy
        for (int i = 0; i < 3; i++) wr_q.push_back({25'(i), rom8[i], 8'd6});
        done_q.push_back(8'd6);
        last_wr = -1;
        ul_before = ul_cycles;
        issue(1'b1, 1'b1, 8'd6, 25'd3);
        repeat (3) @(posedge clk);
        #1 start_upload = 1'b1; index = 8'd9; length = 25'd4;
        @(posedge clk); #1 start_upload = 1'b0;
        wait_done("both", 100);
        repeat (10) @(negedge clk);
        check("both_no_upload", 64'(ul_cycles - ul_before), 64'd0);
        check("both_index", 64'(ioctl_index), 64'd6);
        check_queues("both");

        // Zero-length download
        done_q.push_back(8'd7);
        issue(1'b1, 1'b0, 8'd7, 25'd0);
        @(negedge clk);
        check("zero_done_latency", 64'(done), 64'd1);
        check("zero_no_active", 64'({ioctl_download, busy}), 64'd0);
        @(negedge clk);
        check("zero_done_single", 64'({done, ioctl_download, busy}), 64'd0);
        check_queues("zero");

        // Reset at the third ioctl_wr of a 16-byte download
        for (int i = 0; i < 16; i++) wr_q.push_back({25'(i), src_mem[i], 8'd5});
        last_wr = -1;
        issue(1'b1, 1'b0, 8'd5, 25'd16);
        wcount = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ioctl_wr) wcount++;
            if (wcount == 3) break;
        end
        check("reset_at_3rd_wr", 64'(wcount), 64'd3);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        wr_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        for (int i = 0; i < 2; i++) wr_q.push_back({25'(i), rom8[i], 8'd4});
        done_q.push_back(8'd4);
        last_wr = -1;
        issue(1'b1, 1'b0, 8'd4, 25'd2);
        wait_done("dl2", 100);
        check_queues("dl2");

        // Narrow source address on the second instance
        for (int i = 0; i < 6; i++) wr2_q.push_back({25'(i), 2'(i % 4), src_mem[i % 4]});
        @(posedge clk); #1;
        d2_start_download = 1'b1; d2_index = 8'd1; d2_length = 25'd6;
        @(posedge clk); #1 d2_start_download = 1'b0;
        seen2 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (d2_done) begin seen2 = 1'b1; break; end
        end
        check("d2_done_seen", 64'(seen2), 64'd1);
        @(negedge clk);
        check("d2_done_count", 64'(d2_done_cnt), 64'd1);
        check("d2_queue_empty", 64'(wr2_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
